// File: rtl/mips_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory bus, one transaction outstanding.
// Optional macro ARB_RR_EN selects round-robin priority; default build gives data fixed priority.
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic        i_readdatavalid,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic        d_readdatavalid,
  output logic [31:0] m_readdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_I,
    S_GNT_D,
    S_RDATA_I,
    S_RDATA_D
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_m_readdata;
  logic        r_i_rdv;
  logic        r_d_rdv;
  logic        w_d_req;
  logic        w_pick_data;

  assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
  logic r_last_data;

  // Reset as if data went last so that fetch wins the first contested round.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_data <= 1'b1;
    end else if (r_state == S_IDLE && (i_read || w_d_req)) begin
      r_last_data <= w_pick_data;
    end
  end

  assign w_pick_data = w_d_req && (!i_read || !r_last_data);
`else
  assign w_pick_data = w_d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_data) begin
          w_state_next = S_GNT_D;
        end else if (i_read) begin
          w_state_next = S_GNT_I;
        end
      end
      S_GNT_I: begin
        if (!i_read) begin
          w_state_next = S_IDLE;
        end else if (!waitrequest) begin
          w_state_next = S_RDATA_I;
        end
      end
      S_GNT_D: begin
        // A simultaneous read+write is a write, so it never waits for read data.
        if (!w_d_req) begin
          w_state_next = S_IDLE;
        end else if (!waitrequest) begin
          w_state_next = d_write ? S_IDLE : S_RDATA_D;
        end
      end
      S_RDATA_I, S_RDATA_D: w_state_next = S_IDLE;
      default:              w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    address       = 32'h0;
    writedata     = 32'h0;
    read          = 1'b0;
    write         = 1'b0;
    byteenable    = 4'h0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    grant         = 2'b00;
    case (r_state)
      S_GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'hF;
        i_waitrequest = waitrequest;
        grant         = 2'b01;
      end
      S_GNT_D: begin
        address       = d_address;
        writedata     = d_writedata;
        write         = d_write;
        read          = d_read & ~d_write;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
        grant         = 2'b10;
      end
      S_RDATA_I: grant = 2'b01;
      S_RDATA_D: grant = 2'b10;
      default: ;
    endcase
  end

  // Read data arrives during RDATA_x and is presented, with its valid pulse, one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_readdata <= 32'h0;
      r_i_rdv      <= 1'b0;
      r_d_rdv      <= 1'b0;
    end else begin
      r_i_rdv <= (r_state == S_RDATA_I);
      r_d_rdv <= (r_state == S_RDATA_D);
      if (r_state == S_RDATA_I || r_state == S_RDATA_D) begin
        r_m_readdata <= readdata;
      end
    end
  end

  assign m_readdata      = r_m_readdata;
  assign i_readdatavalid = r_i_rdv;
  assign d_readdatavalid = r_d_rdv;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter; honours ARB_RR_EN when defined.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic        i_readdatavalid;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic        d_readdatavalid;
  logic [31:0] m_readdata;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
    .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid),
    .m_readdata(m_readdata), .address(address), .writedata(writedata),
    .read(read), .write(write), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [107:0] got;
    logic [107:0] exp;
    reset = 1'b0; i_read = 1'b1; d_write = 1'b1; waitrequest = 1'b0;
    d_address = 32'h1234_5678; d_writedata = 32'hFFFF_FFFF; d_byteenable = 4'hF;
    repeat (2) next_cycle;
    #1;
    got = {grant, read, write, address, writedata, byteenable, m_readdata,
           i_readdatavalid, d_readdatavalid, i_waitrequest, d_waitrequest};
    exp = {2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    i_read = 1'b0; d_write = 1'b0; reset = 1'b1;
    next_cycle; #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_release_grant got=%b exp=00", grant); end
    $display("test_reset done");
  endtask

  task automatic test_fetch;
    next_cycle;
    i_address = 32'hBFC0_0000; i_read = 1'b1; waitrequest = 1'b0; #1;
    checks++;
    if (read !== 1'b0) begin errors++; $display("FAIL fetch_idle_read got=%b exp=0", read); end
    next_cycle; #1;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL fetch_n1_read got=%b exp=1", read); end
    checks++;
    if (address !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_addr got=%h exp=bfc00000", address); end
    checks++;
    if (byteenable !== 4'hF) begin errors++; $display("FAIL fetch_be got=%h exp=f", byteenable); end
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL fetch_grant got=%b exp=01", grant); end
    checks++;
    if ({i_waitrequest, d_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL fetch_waitreq got=%b exp=01", {i_waitrequest, d_waitrequest});
    end
    next_cycle;
    i_read = 1'b0; readdata = 32'h2402_1234; #1;
    checks++;
    if ({read, i_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL fetch_n2 got=%b exp=00", {read, i_readdatavalid});
    end
    next_cycle;
    readdata = 32'hDEAD_BEEF; #1;
    checks++;
    if ({i_readdatavalid, d_readdatavalid} !== 2'b10) begin
      errors++; $display("FAIL fetch_n3_rdv got=%b exp=10", {i_readdatavalid, d_readdatavalid});
    end
    checks++;
    if (m_readdata !== 32'h2402_1234) begin errors++; $display("FAIL fetch_n3_data got=%h exp=24021234", m_readdata); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL fetch_n3_grant got=%b exp=00", grant); end
    next_cycle; #1;
    checks++;
    if (i_readdatavalid !== 1'b0) begin errors++; $display("FAIL fetch_n4_rdv got=%b exp=0", i_readdatavalid); end
    checks++;
    if (m_readdata !== 32'h2402_1234) begin errors++; $display("FAIL fetch_hold_data got=%h exp=24021234", m_readdata); end
    $display("test_fetch done");
  endtask

  task automatic test_store;
    int wcnt;
    int dwlow;
    wcnt = 0; dwlow = 0;
    next_cycle;
    d_write = 1'b1; d_address = 32'h0000_0100; d_writedata = 32'h0000_1234;
    d_byteenable = 4'hF; waitrequest = 1'b1; #1;
    if (write) wcnt++;
    if (!d_waitrequest) dwlow++;
    for (int k = 1; k <= 3; k++) begin
      next_cycle;
      waitrequest = (k < 3); #1;
      if (write) wcnt++;
      if (!d_waitrequest) dwlow++;
      checks++;
      if (d_waitrequest !== (k < 3)) begin
        errors++; $display("FAIL store_dwait_c%0d got=%b exp=%b", k, d_waitrequest, (k < 3));
      end
      if (k == 1) begin
        checks++;
        if ({address, writedata, byteenable, grant, i_waitrequest} !== {32'h100, 32'h1234, 4'hF, 2'b10, 1'b1}) begin
          errors++;
          $display("FAIL store_bus got=%h/%h/%h/%b/%b exp=100/1234/f/10/1",
                   address, writedata, byteenable, grant, i_waitrequest);
        end
      end
    end
    next_cycle;
    d_write = 1'b0; waitrequest = 1'b0; #1;
    if (write) wcnt++;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL store_idle_grant got=%b exp=00", grant); end
    next_cycle; #1;
    if (write) wcnt++;
    checks++;
    if (d_readdatavalid !== 1'b0) begin errors++; $display("FAIL store_rdv got=%b exp=0", d_readdatavalid); end
    checks++;
    if (wcnt != 3) begin errors++; $display("FAIL store_write_cycles got=%0d exp=3", wcnt); end
    checks++;
    if (dwlow != 1) begin errors++; $display("FAIL store_dwait_low got=%0d exp=1", dwlow); end
    $display("test_store done");
  endtask

  task automatic test_arbitration;
    logic [1:0] g [3];
    logic [1:0] prev;
    int n;
    n = 0; prev = 2'b00;
    g[0] = 2'b00; g[1] = 2'b00; g[2] = 2'b00;
    reset = 1'b0;
    next_cycle;
    reset = 1'b1;
    next_cycle;
    i_read = 1'b1; i_address = 32'h0000_0040; d_read = 1'b1; d_address = 32'h0000_0080;
    waitrequest = 1'b0; readdata = 32'h1111_1111; #1;
    for (int c = 0; c < 12; c++) begin
      next_cycle; #1;
      if (grant != 2'b00 && prev == 2'b00 && n < 3) begin
        g[n] = grant;
        n++;
      end
      prev = grant;
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) next_cycle;
    checks++;
    if (n != 3) begin errors++; $display("FAIL arb_grant_count got=%0d exp=3", n); end
`ifdef ARB_RR_EN
    checks++;
    if ({g[0], g[1], g[2]} !== 6'b01_10_01) begin
      errors++; $display("FAIL arb_rr_seq got=%b %b %b exp=01 10 01", g[0], g[1], g[2]);
    end
`else
    checks++;
    if ({g[0], g[1]} !== 4'b10_10) begin
      errors++; $display("FAIL arb_fixed_seq got=%b %b exp=10 10", g[0], g[1]);
    end
`endif
    $display("test_arbitration done");
  endtask

  task automatic test_rw_both;
    int rdv;
    rdv = 0;
    next_cycle;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0200;
    d_writedata = 32'hCAFE_F00D; d_byteenable = 4'h3; waitrequest = 1'b0; #1;
    next_cycle; #1;
    checks++;
    if ({write, read} !== 2'b10) begin errors++; $display("FAIL rw_strobes got=%b exp=10", {write, read}); end
    checks++;
    if (address !== 32'h0000_0200) begin errors++; $display("FAIL rw_addr got=%h exp=00000200", address); end
    next_cycle;
    d_read = 1'b0; d_write = 1'b0; #1;
    if (d_readdatavalid) rdv++;
    for (int c = 0; c < 3; c++) begin
      next_cycle; #1;
      if (d_readdatavalid) rdv++;
    end
    checks++;
    if (rdv != 0) begin errors++; $display("FAIL rw_no_rdv got=%0d exp=0", rdv); end
    $display("test_rw_both done");
  endtask

  task automatic test_drop;
    int rdv;
    rdv = 0;
    next_cycle;
    d_read = 1'b1; d_address = 32'h0000_0400; waitrequest = 1'b1; #1;
    next_cycle; #1;
    checks++;
    if ({read, grant} !== 3'b1_10) begin errors++; $display("FAIL drop_gnt got=%b exp=110", {read, grant}); end
    next_cycle;
    d_read = 1'b0; #1;
    checks++;
    if ({read, d_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL drop_same_cycle got=%b exp=01", {read, d_waitrequest});
    end
    next_cycle; #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL drop_idle got=%b exp=00", grant); end
    if (d_readdatavalid) rdv++;
    for (int c = 0; c < 3; c++) begin
      next_cycle; #1;
      if (d_readdatavalid) rdv++;
    end
    checks++;
    if (rdv != 0) begin errors++; $display("FAIL drop_no_rdv got=%0d exp=0", rdv); end
    waitrequest = 1'b0;
    $display("test_drop done");
  endtask

  task automatic test_reset_mid;
    logic [107:0] got;
    logic [107:0] exp;
    next_cycle;
    d_read = 1'b1; d_address = 32'h0000_0300; waitrequest = 1'b0; #1;
    next_cycle; #1;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL rmid_read got=%b exp=1", read); end
    next_cycle;
    d_read = 1'b0; readdata = 32'hAAAA_5555; reset = 1'b0; #1;
    next_cycle; #1;
    got = {grant, read, write, address, writedata, byteenable, m_readdata,
           i_readdatavalid, d_readdatavalid, i_waitrequest, d_waitrequest};
    exp = {2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rmid_outputs got=%h exp=%h", got, exp); end
    reset = 1'b1;
    next_cycle; #1;
    checks++;
    if ({d_readdatavalid, m_readdata} !== 33'h0) begin
      errors++; $display("FAIL rmid_no_rdv got=%b/%h exp=0/0", d_readdatavalid, m_readdata);
    end
    i_read = 1'b1; i_address = 32'h0000_0010;
    next_cycle; #1;
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant got=%b exp=01", grant); end
    next_cycle;
    i_read = 1'b0;
    repeat (3) next_cycle;
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b0; i_address = 32'h0; i_read = 1'b0; d_address = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_writedata = 32'h0; d_byteenable = 4'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_rw_both();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Single clock `clk`; reset port `reset` is synchronous and active-low (reset==0 resets on rising `clk`).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous active-low reset.
REQ-004 i_address  in  32  fetch-port byte address.
REQ-005 i_read  in  1  fetch read request; held until i_waitrequest==0.
REQ-006 i_waitrequest  out  1  fetch stall; 1 unless fetch is granted and the bus accepts.
REQ-007 i_readdatavalid  out  1  one-cycle pulse; m_readdata holds fetch read data.
REQ-008 d_address  in  32  data-port byte address.
REQ-009 d_read / d_write  in  1 each  data-port read/write request; held until d_waitrequest==0.
REQ-010 d_writedata  in  32  store data.
REQ-011 d_byteenable  in  4  store/load lane enables.
REQ-012 d_waitrequest  out  1  data-port stall, same rule as i_waitrequest.
REQ-013 d_readdatavalid  out  1  one-cycle pulse; m_readdata holds data-port read data.
REQ-014 m_readdata  out  32  registered copy of bus readdata, shared by both ports.
REQ-015 address, writedata  out  32 each  shared memory bus.
REQ-016 read, write  out  1 each  shared memory bus strobes.
REQ-017 byteenable  out  4  bus lanes; 4'b1111 for fetch, d_byteenable for data.
REQ-018 waitrequest  in  1  bus stall from memory.
REQ-019 readdata  in  32  bus read data, valid the cycle after a read is accepted.
REQ-020 grant  out  2  debug: 00 none, 01 fetch, 10 data.

Function
REQ-021 FSM states: IDLE, GNT_I, GNT_D, RDATA_I, RDATA_D.
REQ-022 IDLE: any pending request -> registered grant, entering GNT_I or GNT_D next cycle; no bus strobes in IDLE.
REQ-023 Without ARB_RR_EN, priority is fixed: data beats fetch when both pend in the same IDLE cycle.
REQ-024 In GNT_x, bus outputs combinationally follow the granted port's signals; the granted port's waitrequest equals bus waitrequest; the other port's waitrequest is 1.
REQ-025 Acceptance: cycle in GNT_x with waitrequest==0 and read|write asserted.
REQ-026 Accepted write: GNT_D -> IDLE. Accepted read: GNT_x -> RDATA_x.
REQ-027 RDATA_x: capture readdata into m_readdata and pulse x_readdatavalid for exactly one cycle, then go to IDLE.
REQ-028 Minimum latency: request at cycle N, bus strobe at N+1, readdatavalid at N+3 with zero wait states. Each waitrequest cycle adds one cycle.
REQ-029 One transaction outstanding at a time; bus read/write are 0 in IDLE and RDATA_x.
REQ-030 d_read and d_write both high: treated as write; read ignored.
REQ-031 Granted port drops its request before acceptance: strobes fall in the same cycle; FSM returns to IDLE next cycle; no readdatavalid is produced.
REQ-032 m_readdata holds its last value when no readdatavalid is asserted.

Reset
REQ-033 reset==0 at a clock edge forces IDLE, grant=00, read=write=0, address=writedata=0, byteenable=0, m_readdata=0, both readdatavalid=0, both waitrequest=1.
REQ-034 Reset mid-transaction abandons it: no readdatavalid follows, and the next grant is re-arbitrated fresh.

Configuration
REQ-035 Macro ARB_RR_EN. When defined, a registered last-grant bit gives priority in IDLE to the port not granted last, with fetch favoured first after reset. When undefined, REQ-023 fixed priority applies and no last-grant register exists.

Verification
REQ-036 Reset, then i_read=1 at i_address=0xBFC00000, zero-wait memory returning 0x24021234: read=1 at N+1, i_readdatavalid=1 with m_readdata=0x24021234 at N+3, grant returns to 00.
REQ-037 Store: d_write=1, d_address=0x00000100, d_writedata=0x00001234, d_byteenable=4'b1111, waitrequest high for 2 cycles: d_waitrequest=0 only on the third GNT_D cycle; write pulses high exactly 3 cycles.
REQ-038 i_read and d_read asserted together from IDLE, held continuously: without ARB_RR_EN the first two grants are 10 then 10. With ARB_RR_EN the grants are 01 then 10 then 01.
REQ-039 reset driven low during RDATA_D: no d_readdatavalid; all outputs at REQ-033 values the next cycle.
REQ-040 d_read=d_write=1 at 0x00000200: bus write=1 and read=0; no d_readdatavalid is produced.
